// File: rtl/bus_demux3.sv
// -----------------------------------------------------------------------------
// bus_demux3
// Routes a single upstream request to one of three targets by address decode,
// waits for that target's response and returns it upstream. One transaction is
// outstanding at a time. Decode misses and stalled targets both return err=1.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               upstream request handshake
//   req_addr/wen/wdata/wmask          upstream request payload
//   resp_valid/resp_ready             upstream response handshake
//   resp_rdata/resp_err               upstream response payload
//   tgt_req_valid/tgt_req_ready[3]    per-target request handshake
//   tgt_addr/wen/wdata/wmask          registered payload, broadcast to targets
//   tgt_resp_valid/tgt_resp_ready[3]  per-target response handshake
//   tgt_resp_rdata[96]/tgt_resp_err[3] per-target response payload
// -----------------------------------------------------------------------------
module bus_demux3 #(
  parameter logic [31:0] BASE0   = 32'h8000_0000,
  parameter logic [31:0] MASK0   = 32'hF800_0000,
  parameter logic [31:0] BASE1   = 32'hA000_0000,
  parameter logic [31:0] MASK1   = 32'hFFFF_F000,
  parameter logic [31:0] BASE2   = 32'hA000_1000,
  parameter logic [31:0] MASK2   = 32'hFFFF_F000,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [2:0]  tgt_req_valid,
  input  logic [2:0]  tgt_req_ready,
  output logic [31:0] tgt_addr,
  output logic        tgt_wen,
  output logic [31:0] tgt_wdata,
  output logic [3:0]  tgt_wmask,
  input  logic [2:0]  tgt_resp_valid,
  output logic [2:0]  tgt_resp_ready,
  input  logic [95:0] tgt_resp_rdata,
  input  logic [2:0]  tgt_resp_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

  // The counter holds the number of SEND+WAIT cycles already completed, so the
  // TIMEOUT-th cycle is the one in which it reads TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [2:0]  hit;
  logic [2:0]  sel_new;
  logic        sel_req_ready;
  logic        sel_resp_valid;
  logic [31:0] sel_rdata;
  logic        sel_err;
  logic        timeout;

  assign hit[0] = ((req_addr & MASK0) == BASE0);
  assign hit[1] = ((req_addr & MASK1) == BASE1);
  assign hit[2] = ((req_addr & MASK2) == BASE2);

  // Lowest-index hit wins when windows overlap.
  always_comb begin
    sel_new = 3'b000;
    if (hit[0])      sel_new = 3'b001;
    else if (hit[1]) sel_new = 3'b010;
    else if (hit[2]) sel_new = 3'b100;
  end

  // Only the selected target's handshake and payload are ever looked at.
  always_comb begin
    sel_rdata = '0;
    sel_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | tgt_resp_rdata[32*i +: 32];
        sel_err   = sel_err | tgt_resp_err[i];
      end
    end
  end

  assign sel_req_ready  = |(tgt_req_ready & sel_q);
  assign sel_resp_valid = |(tgt_resp_valid & sel_q);
  assign timeout        = (cnt_q >= CNT_LAST);

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wen_d   = req_wen;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          sel_d   = sel_new;
          if (|sel_new) begin
            state_d = SEND;
            cnt_d   = 8'd0;
          end else begin
            state_d = RESP;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end
        end
      end
      SEND: begin
        cnt_d = cnt_q + 8'd1;
        // Only a returned response counts as completion, so an expiring
        // counter beats a request accept in the same cycle.
        if (timeout) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else if (sel_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (sel_resp_valid) begin
          state_d = RESP;
          rdata_d = sel_rdata;
          err_d   = sel_err;
        end else if (timeout) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from flops or decoded state, never from inputs.
  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign tgt_req_valid  = (state_q == SEND) ? sel_q : 3'b000;
  assign tgt_resp_ready = (state_q == WAIT) ? sel_q : 3'b000;
  assign tgt_addr       = addr_q;
  assign tgt_wen        = wen_q;
  assign tgt_wdata      = wdata_q;
  assign tgt_wmask      = wmask_q;

endmodule

// File: tb/tb_bus_demux3.sv
// -----------------------------------------------------------------------------
// tb_bus_demux3
// Self-checking bench for bus_demux3. A transaction-level reference model
// predicts every output each cycle for the main instance (TIMEOUT=8); a second
// instance with TIMEOUT=4 covers the short-timeout case with literal checks.
// -----------------------------------------------------------------------------
module tb_bus_demux3;

  localparam int TO_MAIN = 8;
  localparam logic [31:0] BASES [3] = '{32'h8000_0000, 32'hA000_0000, 32'hA000_1000};
  localparam logic [31:0] MASKS [3] = '{32'hF800_0000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance signals
  logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err, tgt_wen;
  logic [31:0] req_addr, req_wdata, resp_rdata, tgt_addr, tgt_wdata;
  logic [3:0]  req_wmask, tgt_wmask;
  logic [2:0]  tgt_req_valid, tgt_req_ready, tgt_resp_valid, tgt_resp_ready, tgt_resp_err;
  logic [95:0] tgt_resp_rdata;

  // short-timeout instance signals
  logic        t4_req_valid, t4_req_ready, t4_req_wen, t4_resp_valid, t4_resp_ready, t4_resp_err, t4_tgt_wen;
  logic [31:0] t4_req_addr, t4_req_wdata, t4_resp_rdata, t4_tgt_addr, t4_tgt_wdata;
  logic [3:0]  t4_req_wmask, t4_tgt_wmask;
  logic [2:0]  t4_tgt_req_valid, t4_tgt_req_ready, t4_tgt_resp_valid, t4_tgt_resp_ready, t4_tgt_resp_err;
  logic [95:0] t4_tgt_resp_rdata;

  bus_demux3 #(.TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tgt_req_valid(tgt_req_valid), .tgt_req_ready(tgt_req_ready), .tgt_addr(tgt_addr),
    .tgt_wen(tgt_wen), .tgt_wdata(tgt_wdata), .tgt_wmask(tgt_wmask),
    .tgt_resp_valid(tgt_resp_valid), .tgt_resp_ready(tgt_resp_ready),
    .tgt_resp_rdata(tgt_resp_rdata), .tgt_resp_err(tgt_resp_err)
  );

  bus_demux3 #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst),
    .req_valid(t4_req_valid), .req_ready(t4_req_ready), .req_addr(t4_req_addr), .req_wen(t4_req_wen),
    .req_wdata(t4_req_wdata), .req_wmask(t4_req_wmask),
    .resp_valid(t4_resp_valid), .resp_ready(t4_resp_ready), .resp_rdata(t4_resp_rdata), .resp_err(t4_resp_err),
    .tgt_req_valid(t4_tgt_req_valid), .tgt_req_ready(t4_tgt_req_ready), .tgt_addr(t4_tgt_addr),
    .tgt_wen(t4_tgt_wen), .tgt_wdata(t4_tgt_wdata), .tgt_wmask(t4_tgt_wmask),
    .tgt_resp_valid(t4_tgt_resp_valid), .tgt_resp_ready(t4_tgt_resp_ready),
    .tgt_resp_rdata(t4_tgt_resp_rdata), .tgt_resp_err(t4_tgt_resp_err)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model of the main instance
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          busy;   // a request has been accepted and not yet answered
    bit          sent;   // the chosen target has taken the request
    bit          resp;   // a response is being offered upstream
    int          tgt;    // chosen target index, -1 on decode miss
    int          age;    // cycles spent talking to the target
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        err;
  } mdl_t;

  mdl_t m;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & MASKS[i]) == BASES[i]) return i;
    return -1;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.busy = 0; r.sent = 0; r.resp = 0; r.tgt = -1; r.age = 0;
    r.addr = '0; r.wen = 0; r.wdata = '0; r.wmask = '0; r.rdata = '0; r.err = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c);
    mdl_t n = c;
    bit done = 0;
    if (!c.busy) begin
      if (req_valid) begin
        n.busy = 1; n.sent = 0; n.age = 0;
        n.addr = req_addr; n.wen = req_wen; n.wdata = req_wdata; n.wmask = req_wmask;
        n.tgt = decode(req_addr);
        if (n.tgt < 0) begin n.resp = 1; n.rdata = '0; n.err = 1; end
      end
    end else if (c.resp) begin
      if (resp_ready) begin n.busy = 0; n.resp = 0; end
    end else begin
      if (!c.sent) begin
        if (tgt_req_ready[c.tgt]) n.sent = 1;
      end else if (tgt_resp_valid[c.tgt]) begin
        n.resp = 1; n.rdata = tgt_resp_rdata[32*c.tgt +: 32]; n.err = tgt_resp_err[c.tgt];
        done = 1;
      end
      n.age = c.age + 1;
      if (!done && n.age >= TO_MAIN) begin n.resp = 1; n.rdata = '0; n.err = 1; end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= mdl_next(m);
  end

  // Single compare process: every output, every cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("req_ready", 128'(req_ready), 128'(!m.busy));
      check("resp_valid", 128'(resp_valid), 128'(m.busy && m.resp));
      check("tgt_req_valid", 128'(tgt_req_valid),
            128'((m.busy && !m.resp && !m.sent) ? 3'(1 << m.tgt) : 3'b000));
      check("tgt_resp_ready", 128'(tgt_resp_ready),
            128'((m.busy && !m.resp && m.sent) ? 3'(1 << m.tgt) : 3'b000));
      check("tgt_payload", 128'({tgt_addr, tgt_wen, tgt_wdata, tgt_wmask}),
            128'({m.addr, m.wen, m.wdata, m.wmask}));
      if (m.busy && m.resp)
        check("resp_payload", 128'({resp_rdata, resp_err}), 128'({m.rdata, m.err}));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    req_valid = 0; req_addr = '0; req_wen = 0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1; tgt_req_ready = '0; tgt_resp_valid = '0; tgt_resp_rdata = '0; tgt_resp_err = '0;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] k);
    req_valid = 1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = k;
  endtask

  task automatic wait_resp(input string name, input int budget);
    int k = 0;
    while (!resp_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 128'(resp_valid), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    check({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
    check({tag, "_tgt_valids"}, 128'({tgt_req_valid, tgt_resp_ready}), 128'(0));
    check({tag, "_resp_data"}, 128'({resp_rdata, resp_err}), 128'(0));
    check({tag, "_payload"}, 128'({tgt_addr, tgt_wen, tgt_wdata, tgt_wmask}), 128'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    t4_req_valid = 0; t4_req_addr = '0; t4_req_wen = 0; t4_req_wdata = '0; t4_req_wmask = '0;
    t4_resp_ready = 0; t4_tgt_req_ready = '0; t4_tgt_resp_valid = '0;
    t4_tgt_resp_rdata = '0; t4_tgt_resp_err = '0;
    #12;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Read to target 0, target always ready: minimum hit latency.
    @(negedge clk);
    tgt_req_ready = 3'b001; tgt_resp_valid = 3'b001;
    tgt_resp_rdata[31:0] = 32'h1234_5678; tgt_resp_err = '0;
    issue(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    @(negedge clk);                               // after E0
    req_valid = 0;
    check("rd0_tgt_req_valid", 128'(tgt_req_valid), 128'(3'b001));
    check("rd0_req_ready_low", 128'(req_ready), 128'(0));
    @(negedge clk);                               // after E1
    check("rd0_no_early_resp", 128'(resp_valid), 128'(0));
    @(negedge clk);                               // after E2
    check("rd0_resp_valid", 128'(resp_valid), 128'(1));
    check("rd0_resp", 128'({resp_rdata, resp_err}), 128'({32'h1234_5678, 1'b0}));

    // Write to target 2 with request accept delayed three cycles.
    @(negedge clk);
    tgt_req_ready = 3'b000; tgt_resp_valid = 3'b100;
    tgt_resp_rdata[95:64] = 32'h0000_CAFE; tgt_resp_err = 3'b000;
    issue(32'hA000_1004, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 0;
      check("wr2_payload", 128'({tgt_addr, tgt_wen, tgt_wdata, tgt_wmask}),
            128'({32'hA000_1004, 1'b1, 32'hDEAD_BEEF, 4'b0011}));
      check("wr2_tgt_req_valid", 128'(tgt_req_valid), 128'(3'b100));
      if (c == 3) tgt_req_ready = 3'b100;
    end
    wait_resp("wr2_resp_seen", 6);
    check("wr2_resp_err", 128'(resp_err), 128'(0));

    // Decode miss.
    @(negedge clk);
    tgt_req_ready = 3'b111; tgt_resp_valid = 3'b111;
    issue(32'h0000_0000, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    req_valid = 0;
    check("miss_resp_valid", 128'(resp_valid), 128'(1));
    check("miss_no_tgt", 128'(tgt_req_valid), 128'(0));
    check("miss_resp", 128'({resp_rdata, resp_err}), 128'({32'h0, 1'b1}));

    // Stray response from target 0 while waiting on target 2.
    @(negedge clk);
    tgt_req_ready = 3'b100; tgt_resp_valid = 3'b001; tgt_resp_err = 3'b001;
    tgt_resp_rdata = {32'h2222_0002, 32'h0, 32'h0BAD_0BAD};
    issue(32'hA000_1000, 1'b0, 32'h0, 4'h0);
    @(negedge clk);                               // SEND
    req_valid = 0;
    @(negedge clk);                               // WAIT
    check("stray_resp_ready", 128'(tgt_resp_ready), 128'(3'b100));
    @(negedge clk);
    check("stray_ignored", 128'({resp_valid, tgt_resp_ready}), 128'({1'b0, 3'b100}));
    tgt_resp_valid = 3'b101;
    wait_resp("stray_resp_seen", 3);
    check("stray_resp", 128'({resp_rdata, resp_err}), 128'({32'h2222_0002, 1'b0}));

    // Reset pulse during WAIT abandons the transaction.
    @(negedge clk);
    tgt_req_ready = 3'b010; tgt_resp_valid = 3'b000; tgt_resp_err = 3'b000;
    issue(32'hA000_0040, 1'b1, 32'h5555_AAAA, 4'hF);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("rstw_in_wait", 128'(tgt_resp_ready), 128'(3'b010));
    #2 rst = 1'b1;
    #1 check_reset_outputs("rstw");
    @(negedge clk);
    rst = 1'b0;
    tgt_resp_valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstw_no_resp", 128'({resp_valid, req_ready}), 128'({1'b0, 1'b1}));
    end
    idle_inputs();

    // TIMEOUT=4 instance: target 1 accepts but never answers.
    @(negedge clk);
    t4_tgt_req_ready = 3'b010;
    t4_req_valid = 1; t4_req_addr = 32'hA000_0000;
    @(negedge clk);                               // after E0, SEND
    t4_req_valid = 0;
    repeat (2) @(negedge clk);
    @(negedge clk);                               // after E3, 4th cycle
    check("to_still_waiting", 128'({t4_resp_valid, t4_tgt_resp_ready}), 128'({1'b0, 3'b010}));
    @(negedge clk);                               // after E4
    check("to_resp_valid", 128'(t4_resp_valid), 128'(1));
    check("to_resp", 128'({t4_resp_rdata, t4_resp_err}), 128'({32'h0, 1'b1}));
    check("to_dropped", 128'({t4_tgt_req_valid, t4_tgt_resp_ready}), 128'(0));
    t4_tgt_resp_valid = 3'b010; t4_tgt_resp_rdata[63:32] = 32'hFACE_FACE;
    repeat (2) begin
      @(negedge clk);
      check("to_late_ignored", 128'({t4_resp_valid, t4_resp_rdata, t4_resp_err}),
            128'({1'b1, 32'h0, 1'b1}));
    end
    t4_resp_ready = 1;
    @(negedge clk);
    check("to_back_idle", 128'({t4_resp_valid, t4_req_ready, t4_tgt_resp_ready}),
          128'({1'b0, 1'b1, 3'b000}));
    t4_tgt_resp_valid = 3'b000;

    // Randomized traffic against the reference model.
    repeat (3000) begin
      @(negedge clk);
      req_valid = ($urandom % 2) == 0;
      case ($urandom % 4)
        0: req_addr = 32'h8000_0000 | ($urandom & 32'h07FF_FFFF);
        1: req_addr = 32'hA000_0000 | ($urandom & 32'h0000_0FFF);
        2: req_addr = 32'hA000_1000 | ($urandom & 32'h0000_0FFF);
        default: req_addr = $urandom;
      endcase
      req_wen = $urandom % 2;
      req_wdata = $urandom;
      req_wmask = 4'($urandom);
      resp_ready = ($urandom % 2) == 0;
      for (int i = 0; i < 3; i++) begin
        tgt_req_ready[i] = ($urandom % 3) == 0;
        tgt_resp_valid[i] = ($urandom % 3) == 0;
        tgt_resp_err[i] = ($urandom % 4) == 0;
        tgt_resp_rdata[32*i +: 32] = $urandom;
      end
    end

    idle_inputs();
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
